register_file_wb: RTL and testbench

- Architectural register file that consumes the writeback-stage outputs (write enable, destination address, result) and serves the decode stage's two operand reads.
- Includes write-to-read bypass, so a value retiring in writeback is visible to decode in the same cycle.
- Includes a per-register pending-load scoreboard. Decode marks a destination busy when it issues a load; writeback clears the mark. Decode uses the per-port ready flags to stall on load-use hazards.

---
 rtl/register_file_wb.sv | 109 ++++++++++
 tb/tb_register_file_wb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_wb.sv
// Architectural register file fed by writeback and read by decode, with
// write-to-read bypass and a per-register pending-load scoreboard.
module register_file_wb #(
    parameter int AWL = 6,
    parameter int DWL = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RFWEW,
    input  logic [AWL-2:0]        RFAW,
    input  logic [DWL-1:0]        ResultW,
    input  logic [AWL-2:0]        RFRA1,
    input  logic [AWL-2:0]        RFRA2,
    output logic [DWL-1:0]        RFRD1,
    output logic [DWL-1:0]        RFRD2,
    input  logic                  BusySet,
    input  logic [AWL-2:0]        BusyA,
    output logic                  Ready1,
    output logic                  Ready2,
    output logic [2**(AWL-1)-1:0] BusyVec
);

    localparam int AW   = AWL - 1;
    localparam int NREG = 2 ** AW;

    logic [DWL-1:0]  regs_q [NREG];
    logic [DWL-1:0]  regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            wr_en_s;
    logic            set_en_s;

    assign wr_en_s  = RFWEW && (RFAW != {AW{1'b0}});
    assign set_en_s = BusySet && (BusyA != {AW{1'b0}});

    // Next-state for the register array: reset clears, writeback updates.
    always_comb begin
        regs_d = regs_q;
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = {DWL{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_d[RFAW] = ResultW;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {DWL{1'b0}};
    end

    // Next-state for the scoreboard; the set is applied after the clear so a
    // new load to the register retiring this cycle stays pending.
    always_comb begin
        busy_d = busy_q;
        if (RST) begin
            busy_d = {NREG{1'b0}};
        end else begin
            if (wr_en_s) begin
                busy_d[RFAW] = 1'b0;
            end else begin
                busy_d = busy_q;
            end
            if (set_en_s) begin
                busy_d[BusyA] = 1'b1;
            end else begin
                busy_d[0] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // State registers for array and scoreboard.
    always_ff @(posedge CLK) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    // Read port 1: zero register, bypass from writeback, else array.
    always_comb begin
        if (RFRA1 == {AW{1'b0}}) begin
            RFRD1  = {DWL{1'b0}};
            Ready1 = 1'b1;
        end else if (RFWEW && (RFAW == RFRA1)) begin
            RFRD1  = ResultW;
            Ready1 = 1'b1;
        end else begin
            RFRD1  = regs_q[RFRA1];
            Ready1 = ~busy_q[RFRA1];
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        if (RFRA2 == {AW{1'b0}}) begin
            RFRD2  = {DWL{1'b0}};
            Ready2 = 1'b1;
        end else if (RFWEW && (RFAW == RFRA2)) begin
            RFRD2  = ResultW;
            Ready2 = 1'b1;
        end else begin
            RFRD2  = regs_q[RFRA2];
            Ready2 = ~busy_q[RFRA2];
        end
    end

    assign BusyVec = busy_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed self-checking bench for register_file_wb.
module tb_register_file_wb;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RFWEW = 1'b0;
    logic [4:0]  RFAW = 5'd0;
    logic [31:0] ResultW = 32'd0;
    logic [4:0]  RFRA1 = 5'd0;
    logic [4:0]  RFRA2 = 5'd0;
    logic [31:0] RFRD1;
    logic [31:0] RFRD2;
    logic        BusySet = 1'b0;
    logic [4:0]  BusyA = 5'd0;
    logic        Ready1;
    logic        Ready2;
    logic [31:0] BusyVec;

    int checks = 0;
    int failures = 0;

    register_file_wb #(.AWL(6), .DWL(32)) dut (
        .CLK(CLK), .RST(RST), .RFWEW(RFWEW), .RFAW(RFAW), .ResultW(ResultW),
        .RFRA1(RFRA1), .RFRA2(RFRA2), .RFRD1(RFRD1), .RFRD2(RFRD2),
        .BusySet(BusySet), .BusyA(BusyA), .Ready1(Ready1), .Ready2(Ready2),
        .BusyVec(BusyVec)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        RST = 1'b0; RFWEW = 1'b0; RFAW = 5'd0; ResultW = 32'd0;
        BusySet = 1'b0; BusyA = 5'd0;
    endtask

    task automatic test_reset;
        logic [4:0] addrs [3];
        addrs[0] = 5'd0; addrs[1] = 5'd5; addrs[2] = 5'd31;
        idle();
        RST = 1'b1;
        tick();
        idle();
        foreach (addrs[k]) begin
            RFRA1 = addrs[k]; RFRA2 = addrs[k];
            #1;
            checks++;
            if (RFRD1 !== 32'd0 || RFRD2 !== 32'd0) begin
                failures++;
                $display("FAIL reset_rd addr=%0d got=%h/%h exp=0", addrs[k], RFRD1, RFRD2);
            end
            checks++;
            if (Ready1 !== 1'b1 || Ready2 !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready addr=%0d got=%b/%b exp=1", addrs[k], Ready1, Ready2);
            end
        end
        checks++;
        if (BusyVec !== 32'd0) begin
            failures++;
            $display("FAIL reset_busyvec got=%h exp=0", BusyVec);
        end
    endtask

    task automatic test_bypass;
        idle();
        RFWEW = 1'b1; RFAW = 5'd7; ResultW = 32'hDEADBEEF; RFRA1 = 5'd7; RFRA2 = 5'd8;
        #1;
        checks++;
        if (RFRD1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_rd1 got=%h exp=%h", RFRD1, 32'hDEADBEEF);
        end
        checks++;
        if (RFRD2 !== 32'd0) begin
            failures++;
            $display("FAIL bypass_other_port got=%h exp=0", RFRD2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (RFRD1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL array_rd1 got=%h exp=%h", RFRD1, 32'hDEADBEEF);
        end
    endtask

    task automatic test_zero_reg;
        idle();
        RFWEW = 1'b1; RFAW = 5'd0; ResultW = 32'h1234;
        BusySet = 1'b1; BusyA = 5'd0;
        RFRA1 = 5'd0; RFRA2 = 5'd0;
        #1;
        checks++;
        if (RFRD1 !== 32'd0 || RFRD2 !== 32'd0 || Ready1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_same_cycle got=%h/%h rdy=%b exp=0/0 rdy=1", RFRD1, RFRD2, Ready1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (RFRD1 !== 32'd0 || RFRD2 !== 32'd0) begin
            failures++;
            $display("FAIL zero_later got=%h/%h exp=0", RFRD1, RFRD2);
        end
        checks++;
        if (BusyVec !== 32'd0) begin
            failures++;
            $display("FAIL zero_busy got=%h exp=0", BusyVec);
        end
    endtask

    task automatic test_load_use;
        idle();
        BusySet = 1'b1; BusyA = 5'd9;
        tick();
        idle();
        RFRA2 = 5'd9;
        #1;
        checks++;
        if (Ready2 !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_stall got=%b exp=0", Ready2);
        end
        checks++;
        if (BusyVec !== 32'h0000_0200) begin
            failures++;
            $display("FAIL loaduse_busyvec got=%h exp=%h", BusyVec, 32'h0000_0200);
        end
        RFWEW = 1'b1; RFAW = 5'd9; ResultW = 32'hA5A5A5A5;
        #1;
        checks++;
        if (Ready2 !== 1'b1 || RFRD2 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL loaduse_bypass got=%b/%h exp=1/%h", Ready2, RFRD2, 32'hA5A5A5A5);
        end
        tick();
        idle();
        #1;
        checks++;
        if (BusyVec !== 32'd0 || Ready2 !== 1'b1 || RFRD2 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL loaduse_after got=%h/%b/%h exp=0/1/%h", BusyVec, Ready2, RFRD2, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_same_edge;
        idle();
        BusySet = 1'b1; BusyA = 5'd4;
        RFWEW = 1'b1; RFAW = 5'd4; ResultW = 32'h4444_4444;
        tick();
        idle();
        RFRA1 = 5'd4;
        #1;
        checks++;
        if (BusyVec !== 32'h0000_0010 || Ready1 !== 1'b0) begin
            failures++;
            $display("FAIL same_addr_busy got=%h rdy=%b exp=%h rdy=0", BusyVec, Ready1, 32'h0000_0010);
        end
        checks++;
        if (RFRD1 !== 32'h4444_4444) begin
            failures++;
            $display("FAIL same_addr_data got=%h exp=%h", RFRD1, 32'h4444_4444);
        end
        BusySet = 1'b1; BusyA = 5'd6;
        tick();
        idle();
        #1;
        checks++;
        if (BusyVec !== 32'h0000_0050) begin
            failures++;
            $display("FAIL set_two got=%h exp=%h", BusyVec, 32'h0000_0050);
        end
        BusySet = 1'b1; BusyA = 5'd4;
        RFWEW = 1'b1; RFAW = 5'd6; ResultW = 32'h66;
        tick();
        idle();
        RFRA2 = 5'd6;
        #1;
        checks++;
        if (BusyVec !== 32'h0000_0010) begin
            failures++;
            $display("FAIL diff_addr got=%h exp=%h", BusyVec, 32'h0000_0010);
        end
        checks++;
        if (RFRD2 !== 32'h66 || Ready2 !== 1'b1) begin
            failures++;
            $display("FAIL diff_addr_rd got=%h/%b exp=%h/1", RFRD2, Ready2, 32'h66);
        end
    endtask

    task automatic test_reset_mid;
        idle();
        RFWEW = 1'b1; RFAW = 5'd3; ResultW = 32'h55;
        tick();
        idle();
        BusySet = 1'b1; BusyA = 5'd12;
        tick();
        idle();
        RFRA1 = 5'd3;
        #1;
        checks++;
        if (RFRD1 !== 32'h55 || BusyVec !== 32'h0000_1010) begin
            failures++;
            $display("FAIL pre_reset got=%h/%h exp=%h/%h", RFRD1, BusyVec, 32'h55, 32'h0000_1010);
        end
        RST = 1'b1; RFWEW = 1'b1; RFAW = 5'd3; ResultW = 32'h77;
        BusySet = 1'b1; BusyA = 5'd5;
        tick();
        idle();
        #1;
        checks++;
        if (BusyVec !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_busy got=%h exp=0", BusyVec);
        end
        for (int a = 0; a < 32; a++) begin
            RFRA1 = 5'(a); RFRA2 = 5'(31 - a);
            #1;
            checks++;
            if (RFRD1 !== 32'd0 || RFRD2 !== 32'd0 || Ready1 !== 1'b1 || Ready2 !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset_rd addr=%0d got=%h/%h rdy=%b%b exp=0/0 rdy=11",
                         a, RFRD1, RFRD2, Ready1, Ready2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_load_use();
        test_same_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
